// File: rtl/iq_pkg.sv
// Shared definitions for the instruction queue: word widths, the end-marker
// opcode, the fetch state encoding and the entry format held in the buffer.
package iq_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [5:0] OPC_END = 6'b111111;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  // One queued instruction together with the word index it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/iq_fifo.sv
// Circular buffer for queued instructions. Read/write pointers are
// log2(DEPTH) bits wide and wrap naturally; a separate occupancy count
// distinguishes full from empty. flush_i empties the buffer in one cycle.
module iq_fifo
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  entry_t                   data_i,
  output entry_t                   data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_queue.sv
// Instruction fetch queue: fetches sequential words from instruction memory
// into a circular buffer until an end marker is seen, presents the head entry
// to the issue stage, and restarts from a new index on a branch redirect.
// Optional macro INSTR_QUEUE_STATS_EN adds a saturating stall_cycles counter
// of FETCH cycles in which a push was blocked by a full queue with no pop.
module instr_queue
  import iq_pkg::*;
#(
  parameter int unsigned     DEPTH    = 8,
  parameter logic [PC_W-1:0] PC_RESET = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               isend,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               issue_ready,
  output logic               done
`ifdef INSTR_QUEUE_STATS_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [AW:0]     count;
  logic            full;
  logic            push;
  logic            pop;
  entry_t          head;

  assign full = (count == (AW+1)'(DEPTH));

  // A redirect flushes the buffer, so neither push nor pop is meaningful then.
  assign pop  = out_valid && issue_ready && !redirect_valid;
  assign push = (state_q == FETCH) && !isend && !redirect_valid && (!full || pop);

  iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ('{pc: pc_q, instr: instr}),
    .data_o  (head),
    .count_o (count)
  );

  // Fetch FSM and fetch index: redirect overrides end-marker and push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
    end else if (redirect_valid) begin
      state_q <= FETCH;
      pc_q    <= redirect_pc;
    end else begin
      case (state_q)
        FETCH: begin
          if (isend)     state_q <= HALT;
          else if (push) pc_q    <= pc_q + 1'b1;
        end
        HALT:    ;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign pc        = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign done      = (state_q == HALT) && (count == '0);

`ifdef INSTR_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q;
  logic        stall;

  assign stall = (state_q == FETCH) && !redirect_valid && !isend && full && !pop;

  // Saturating count of fetch cycles lost to a full queue; survives redirects.
  always_ff @(posedge clk) begin
    if (rst)                                  stall_cycles_q <= '0;
    else if (stall && stall_cycles_q != '1)   stall_cycles_q <= stall_cycles_q + 1'b1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios for the documented
// behaviours followed by randomized traffic compared against a queue model.
module tb_instr_queue;
  import iq_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] PC_RESET = 32'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        isend;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        issue_ready;
  logic        done;
`ifdef INSTR_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
`endif

  // Instruction memory: 64 words, indexed by the low bits of pc.
  logic [31:0] mem [64];
  assign instr = mem[pc[5:0]];
  assign isend = (instr[31:26] == OPC_END);

  instr_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instr          (instr),
    .isend          (isend),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .issue_ready    (issue_ready),
    .done           (done)
`ifdef INSTR_QUEUE_STATS_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of fetched words plus the fetch index.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  longint      m_stall;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] add_word();
    logic [31:0] w;
    w = {6'b000000, 20'($urandom), 6'h20};
    return w;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = {6'($urandom_range(0, 62)), 26'($urandom)};
    return w;
  endfunction

  function automatic logic [31:0] end_word();
    logic [31:0] w;
    w = {OPC_END, 26'($urandom)};
    return w;
  endfunction

  task automatic fill_add();
    for (int i = 0; i < 64; i++) mem[i] = add_word();
  endtask

  task automatic model_update(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit          do_pop;
    bit          do_push;
    logic [31:0] w;
    ent_t        e;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (r) begin
      mq.delete();
      m_pc    = PC_RESET;
      m_halt  = 1'b0;
      m_stall = 0;
    end else if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      w      = mem[m_pc[5:0]];
      do_pop = (mq.size() > 0) && rdy;
      if (!m_halt) begin
        if (w[31:26] == OPC_END)                      m_halt = 1'b1;
        else if (mq.size() < DEPTH || do_pop)         do_push = 1'b1;
        else if (m_stall < 64'h0000_0000_FFFF_FFFF)   m_stall++;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc    = m_pc;
        e.instr = w;
        mq.push_back(e);
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
    end else begin
      check("out_pc_empty", out_pc, 0);
      check("out_instr_empty", out_instr, 0);
    end
    check("done", done, m_halt && mq.size() == 0);
`ifdef INSTR_QUEUE_STATS_EN
    check("stall_cycles", stall_cycles, m_stall[31:0]);
`endif
  endtask

  // One clock: drive inputs at the falling edge, update the model at the
  // rising edge, then compare everything at the next falling edge.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    issue_ready    = rdy;
    @(posedge clk);
    model_update(r, rv, rpc, rdy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] prev_out;
    bit          seen_done;
    int          p_rdy;
    logic [31:0] rpc;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
    fill_add();
    @(negedge clk);

    // Short program: four ADDs then an end marker, issue always ready.
    fill_add();
    mem[4] = end_word();
    step(1, 0, 0, 1);
    check("p1_reset_pc", pc, PC_RESET);
    check("p1_reset_valid", out_valid, 0);
    for (int c = 1; c <= 5; c++) begin
      step(0, 0, 0, 1);
      if (c <= 4) check("p1_out_pc", out_pc, 32'(c - 1));
      else begin
        check("p1_done", done, 1);
        check("p1_halt_pc", pc, 32'd4);
      end
    end

    // Fill with issue stalled: exactly DEPTH pushes then stall counting.
    fill_add();
    step(1, 0, 0, 0);
    for (int c = 1; c <= 20; c++) step(0, 0, 0, 0);
    check("fill_pc", pc, 32'd8);
    check("fill_valid", out_valid, 1);
`ifdef INSTR_QUEUE_STATS_EN
    check("fill_stall", stall_cycles, 32'd12);
`endif

    // Full queue with issue ready: push and pop every cycle.
    for (int c = 0; c < 10; c++) begin
      prev_pc  = pc;
      prev_out = out_pc;
      step(0, 0, 0, 1);
      check("full_pc_adv", pc, prev_pc + 32'd1);
      check("full_out_inc", out_pc, prev_out + 32'd1);
    end

    // Redirect with five entries queued.
    step(1, 0, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);
    check("redir_valid", out_valid, 0);
    check("redir_pc", pc, 32'h40);
    step(0, 0, 0, 1);
    check("redir_out_pc", out_pc, 32'h40);

    // Redirect out of HALT.
    fill_add();
    mem[2] = end_word();
    step(1, 0, 0, 1);
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      step(0, 0, 0, 1);
      seen_done = done;
    end
    check("halt_done", done, 1);
    step(0, 1, 32'h10, 1);
    check("halt_redir_done", done, 0);
    check("halt_redir_pc", pc, 32'h10);
    step(0, 0, 0, 1);
    check("halt_redir_out", out_pc, 32'h10);

    // Reset overriding a simultaneous redirect with entries queued.
    fill_add();
    step(1, 0, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0);
    step(1, 1, 32'h55, 0);
    check("rst_pc", pc, PC_RESET);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);

    // Randomized traffic, including redirects near the 32-bit wrap point.
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 9) == 0) ? end_word() : rand_word();
    step(1, 0, 0, 0);
    for (int ph = 0; ph < 6; ph++) begin
      p_rdy = $urandom_range(10, 95);
      for (int c = 0; c < 500; c++) begin
        case ($urandom_range(0, 3))
          0:       rpc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          1:       rpc = 32'($urandom_range(0, 63));
          default: rpc = $urandom;
        endcase
        step($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, rpc,
             $urandom_range(1, 100) <= p_rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; SHALL be a power of two, 2..64.
REQ-002 Parameter PC_RESET, default 32'd0, fetch word-index after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc  output  32  word index driven to the instruction memory (combinational lookup, result same cycle).
REQ-006 instr  input  32  instruction word returned for pc.
REQ-007 isend  input  1  high when instr[31:26]==6'b111111 (end marker).
REQ-008 redirect_valid  input  1  branch resolution: flush and refetch.
REQ-009 redirect_pc  input  32  new fetch word-index.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_instr  output  32  head instruction.
REQ-012 out_pc  output  32  word index of head instruction.
REQ-013 issue_ready  input  1  issue stage accepts head this cycle.
REQ-014 done  output  1  high when halted and queue empty.

Function
REQ-015 States FETCH and HALT; a push SHALL occur in FETCH when !isend and (count<DEPTH or pop this cycle).
REQ-016 Pop SHALL occur when out_valid && issue_ready; out_* SHALL come from registered storage, never from instr combinationally.
REQ-017 On a push, pc SHALL advance by 1 (32-bit wrap 0xFFFFFFFF->0); no push leaves pc unchanged.
REQ-018 In FETCH with isend high, the end word SHALL NOT be pushed, pc SHALL hold, next state HALT.
REQ-019 In HALT no push SHALL occur; pops continue; done = (state==HALT) && count==0.
REQ-020 Full with simultaneous pop: push and pop both occur, count unchanged; empty: no pop, out_valid 0.
REQ-021 redirect_valid SHALL have priority over push, pop and isend in that cycle: count->0, pc->redirect_pc, state->FETCH; first new push the following cycle.
REQ-022 Fetch-to-out_valid latency SHALL be 1 cycle from an empty queue.
REQ-023 Storage SHALL be a circular buffer with read/write pointers of log2(DEPTH) bits wrapping naturally.

Reset
REQ-024 On rst: pc=PC_RESET, state=FETCH, count=0, pointers=0, out_valid=0, out_instr=0, out_pc=0, done=0.
REQ-025 rst SHALL override redirect_valid and any in-flight push/pop; storage contents need not be cleared.

Configuration
REQ-026 Macro INSTR_QUEUE_STATS_EN: when defined, add output stall_cycles [31:0], reset 0, +1 each FETCH cycle a push is blocked by full without pop, saturating at 0xFFFFFFFF, not cleared by redirect; when undefined, port and counter SHALL be absent.

Structure
REQ-027 Shared package iq_pkg SHALL hold OPC_END=6'b111111, INSTR_W=32, PC_W=32 and the FETCH/HALT state encoding.
REQ-028 Circular buffer SHALL be sub-module iq_fifo (push, pop, data in/out, count); instr_queue holds pc, state and control.

Verification
REQ-029 Reset, memory words 0..3 = ADD opcodes, word 4 end marker, issue_ready=1 -> out_pc 0,1,2,3 on cycles 1..4, state HALT at pc=4, done=1 at cycle 5.
REQ-030 issue_ready=0, 20 non-end words -> exactly 8 pushes, pc=8, out_valid=1, (stats) stall_cycles increments from cycle 9.
REQ-031 Queue full, issue_ready=1 -> one push and one pop per cycle, count stays 8, out_pc strictly increasing.
REQ-032 Queue holds 5 entries, redirect_valid=1 redirect_pc=0x40 -> next cycle out_valid=0, pc=0x40; following cycle out_pc=0x40.
REQ-033 In HALT, redirect_pc=0x10 -> state FETCH, done=0, fetching resumes at 0x10.
REQ-034 rst asserted with 3 entries and simultaneous redirect -> pc=PC_RESET, out_valid=0, count=0 next cycle.
